uart_receiver: RTL and testbench
================================

# uart_receiver

Asynchronous serial receiver for the console/debug link: the receive-side counterpart of the existing 8N1 UART transmitter, running at the same clk_divider-derived bit rate. It oversamples the pin in the system clock domain, validates start and stop bits, and delivers bytes through a small FIFO with a valid/ready handshake. It sits in the SOC next to the transmitter, driven from the PLL clock, so the PSRAM test can accept host commands.

## Interface
- clk_divider, default 200: system clocks per bit (50 MHz / 200 = 250 kbaud); legal range ≥ 8.
- FIFO_DEPTH, default 4: receive FIFO entries; power of two, ≥ 2.
- i_clk  in  1  system clock. One clock; all logic on its rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_uart_rx  in  1  serial line, idle high, asynchronous to i_clk.
- o_data  out  8  head-of-FIFO byte; valid only while o_valid.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: completed byte dropped because FIFO full.
- o_busy  out  1  high whenever FSM is not IDLE.

## Operation
- Input: 2-flop synchronizer, both flops reset to 1; FSM uses the second flop (rx_s).
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on rx_s == 0, load counter with clk_divider/2 − 1 (integer division), go START.
- START: on counter zero, sample rx_s. 1 → false start, back to IDLE, nothing reported. 0 → load clk_divider − 1, bit index = 0, go DATA.
- DATA: on each counter zero, shift rx_s into bit [index], LSB first; reload clk_divider − 1; after index 7, go STOP.
- STOP: on counter zero, sample rx_s. 1 → push byte, go IDLE. 0 → pulse o_frame_err, discard byte, go BREAK.
- BREAK: stay until rx_s == 1, then IDLE. No start detection while in BREAK.
- Counter width $clog2(clk_divider); decrement-to-zero, no wrap beyond reload.
- FIFO: push from STOP, pop on o_valid && i_ready. Push while full with no same-cycle pop → byte dropped, o_overrun pulse, contents unchanged. Push and pop in the same cycle while full → both take effect, count unchanged, no overrun. Push and pop in the same cycle while empty → push only (o_valid was 0).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- Reset (any time, including mid-frame): FSM → IDLE, FIFO emptied, synchronizer → 1, partially received byte lost.
- Reset values: o_data 0, o_valid 0, o_frame_err 0, o_overrun 0, o_busy 0.

## Timing
- Pin to rx_s: 2 cycles.
- Let cycle 0 be the first cycle in IDLE with rx_s == 0. Start sample at cycle clk_divider/2. Data bit k is sampled at clk_divider/2 + (k+1)·clk_divider. Stop sample is at clk_divider/2 + 9·clk_divider; the FIFO write happens on that edge.
- o_valid rises the cycle after the push (the FIFO is registered; there is no fall-through path).
- o_frame_err and o_overrun assert for exactly one cycle, in the cycle after the stop sample.
- Back-to-back frames: IDLE is re-entered at the stop-bit midpoint, so the next start edge is caught with half a bit of margin. Tolerated rate mismatch is about ±4%.
- o_data/o_valid change only on pop or on a push into an empty FIFO. They hold while o_valid && !i_ready.

## Structure
- Shared package uart_pkg: FSM state enum (5 states, 3 bits) and the default bit-rate constant (200), which the transmitter also uses.
- One sub-module: uart_rx_fifo, a synchronous FIFO with parameter FIFO_DEPTH, 8-bit width, push/pop/full/empty, async active-low reset.
- Top file holds the synchronizer, the bit counter and the FSM.

## Test plan
- clk_divider=16: send 0x55 then 0xA3 back-to-back with i_ready=1 → o_data 0x55 then 0xA3, one cycle of o_valid each; o_valid rises 2+8+144+1 cycles after the pin's falling edge.
- Low glitch of 5 cycles on an idle line → no o_valid, no o_frame_err; o_busy high for ≤ 8 cycles, then IDLE.
- Frame 0x3C with stop bit forced low, line held low 40 cycles and then released → one o_frame_err pulse, no push; a following 0x81 frame is received correctly.
- i_ready=0, send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 → o_overrun pulses once on the 5th byte; draining yields 0x01..0x04 in order, then o_valid=0.
- FIFO full with i_ready asserted on exactly the cycle of the stop sample of a 5th byte 0x77 → no o_overrun; the drain order ends with 0x77.
- Assert i_rst_n=0 during data bit 3 of a frame, then release → all outputs 0 immediately; the next full frame 0xE7 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   CLK_DIVIDER_DEFAULT : system clocks per bit (50 MHz / 200 = 250 kbaud)
//   rx_state_t          : receiver FSM state encoding (5 states, 3 bits)
package uart_pkg;

  localparam int unsigned CLK_DIVIDER_DEFAULT = 200;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO between the receiver FSM and the consumer.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata : write request and byte
//   pop         : read request (ignored while empty)
//   rdata       : head-of-FIFO byte, 0 while empty
//   full, empty : occupancy flags
// A push while full is taken only when a pop happens on the same edge.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gating with empty keeps the output at 0 after reset without clearing the array.
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver with a small receive FIFO.
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_uart_rx      : serial line, idle high, asynchronous to i_clk
//   o_data/o_valid : head-of-FIFO byte / FIFO non-empty
//   i_ready        : consumer takes o_data when o_valid && i_ready
//   o_frame_err    : one-cycle pulse, stop bit sampled low
//   o_overrun      : one-cycle pulse, completed byte dropped (FIFO full)
//   o_busy         : FSM is not IDLE
module uart_receiver
  import uart_pkg::*;
#(
  parameter int clk_divider = CLK_DIVIDER_DEFAULT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(clk_divider);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(clk_divider / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(clk_divider - 1);

  rx_state_t        state;
  logic             rx_m;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;

  // Stage boundary: two-flop synchronizer, reset to the idle level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
    end
  end

  // A good stop bit writes the byte on the same edge it is sampled.
  assign push    = (state == STOP) && (cnt == '0) && rx_s;
  assign o_valid = !fifo_empty;
  assign o_busy  = (state != IDLE);

  // Stage boundary: bit-timing counter and frame FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      // Full FIFO only accepts the byte when the consumer pops on the same edge.
      o_overrun   <= push && fifo_full && !i_ready;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_RELOAD;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt     <= FULL_RELOAD;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            cnt <= FULL_RELOAD;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            // Returning to IDLE at mid stop bit leaves half a bit to catch the next start.
            if (rx_s) begin
              state <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data shift register; LSB arrives first.
  always_ff @(posedge i_clk) begin
    if (state == DATA && cnt == '0) shreg[bit_idx] <= rx_s;
  end

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .wdata (shreg),
    .pop   (i_ready),
    .rdata (o_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver with clk_divider = 16,
// FIFO_DEPTH = 4. Expected bytes go into a queue as frames are sent and are
// popped and compared whenever the DUT hands a byte over.
module tb_uart_receiver;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int valid_cyc = 0;
  int busy_cyc = 0;

  uart_receiver #(
    .clk_divider(D),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_uart_rx  (rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(ferr),
    .o_overrun  (ovr),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ferr)  ferr_cnt++;
      if (ovr)   ovr_cnt++;
      if (valid) valid_cyc++;
      if (busy)  busy_cyc++;
      if (valid && ready) begin
        if (exp_q.size() == 0) check("sb_extra_byte", 32'(data), 32'h100);
        else                   check("sb_data", 32'(data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int extra_low);
    rx = 1'b0;
    tick(D);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(D);
    end
    rx = stop_bit;
    tick(D);
    if (extra_low > 0) begin
      rx = 1'b0;
      tick(extra_low);
    end
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    logic [7:0] b;

    // Reset state
    tick(3);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    check("rst_ovr", 32'(ovr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Back-to-back 0x55, 0xA3 with latency measurement
    ready = 1'b1;
    valid_cyc = 0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    lat = 0;
    fork
      begin
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'hA3, 1'b1, 0);
      end
      begin
        while (lat < 400) begin
          @(posedge clk);
          lat++;
          #1;
          if (valid) break;
        end
      end
    join
    check("valid_latency", 32'(lat), 32'd155);
    wait_drain("drain_b2b", 4 * D);
    tick(2);
    check("valid_cycles_b2b", 32'(valid_cyc), 32'd2);

    // Short low glitch: false start
    base = ferr_cnt;
    busy_cyc = 0;
    valid_cyc = 0;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(40);
    check("glitch_busy_seen", 32'(busy_cyc > 0), 32'd1);
    check("glitch_busy_le8", 32'(busy_cyc <= 8), 32'd1);
    check("glitch_no_valid", 32'(valid_cyc), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt), 32'(base));
    check("glitch_idle", 32'(busy), 32'd0);

    // Framing error with line held low, then a good frame
    base = ferr_cnt;
    valid_cyc = 0;
    send_byte(8'h3C, 1'b0, 40);
    tick(2 * D);
    check("ferr_one_pulse", 32'(ferr_cnt), 32'(base + 1));
    check("ferr_no_push", 32'(valid_cyc), 32'd0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1, 0);
    wait_drain("drain_after_ferr", 4 * D);
    check("ferr_no_extra", 32'(ferr_cnt), 32'(base + 1));

    // Overrun: five bytes into a four-entry FIFO
    ready = 1'b0;
    base = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 0);
    end
    tick(D);
    check("overrun_once", 32'(ovr_cnt), 32'(base + 1));
    check("full_valid", 32'(valid), 32'd1);
    check("full_head", 32'(data), 32'h01);
    ready = 1'b1;
    wait_drain("drain_overrun", 20);
    tick(2);
    check("drained_valid", 32'(valid), 32'd0);

    // Full FIFO with a pop on exactly the stop-sample edge of a 5th byte
    ready = 1'b0;
    base = ovr_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 0);
    exp_q.push_back(8'h77);
    fork
      send_byte(8'h77, 1'b1, 0);
      begin
        repeat (154) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    tick(D);
    check("simul_push_pop_no_ovr", 32'(ovr_cnt), 32'(base));
    check("simul_head", 32'(data), 32'h22);
    ready = 1'b1;
    wait_drain("drain_simul", 20);
    tick(2);
    check("simul_drained", 32'(valid), 32'd0);

    // Reset mid-frame with a byte already buffered
    ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, 0);
    tick(2);
    check("pre_rst_valid", 32'(valid), 32'd1);
    check("pre_rst_data", 32'(data), 32'h5A);
    b = 8'hE7;
    rx = 1'b0;
    tick(D);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      tick(D);
    end
    rx = b[3];
    tick(D / 2);
    check("midframe_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(data), 32'h0);
    check("async_rst_valid", 32'(valid), 32'h0);
    check("async_rst_ferr", 32'(ferr), 32'h0);
    check("async_rst_ovr", 32'(ovr), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    exp_q.delete();
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    ready = 1'b1;
    valid_cyc = 0;
    exp_q.push_back(8'hE7);
    send_byte(8'hE7, 1'b1, 0);
    wait_drain("drain_after_rst", 4 * D);
    tick(2);
    check("after_rst_one_byte", 32'(valid_cyc), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
